mem_wb_bus_master: RTL and testbench
====================================

// Module: mem_wb_bus_master
// PURPOSE
// - Memory-stage data bus initiator: consumes the load/store operation latched by the EX/MEM register
//   (aluop, effective address, store data) and runs one Wishbone-classic cycle per access.
// - Steers byte lanes (big-endian), sign/zero-extends loads, holds the pipeline via stallreq_o
//   until ack, and presents the writeback triple toward MEM/WB.
// PARAMETERS
// - TIMEOUT  16  cycles in BUSY without ack before abort; 0 disables timeout
// PORTS
// - clk            in   1   clock, all state on rising edge
// - rst            in   1   reset, asynchronous, active-low
// - mem_aluop_i    in   8   operation from EX/MEM (`AluOpBus)
// - mem_addr_i     in   32  effective byte address
// - mem_reg2_i     in   32  store data
// - mem_wd_i       in   5   dest register; mem_wreg_i in 1 write enable; mem_wdata_i in 32 non-load result
// - stall_i        in   6   pipeline stall vector; bit 4 = MEM/WB hold
// - flush_i        in   1   abort current instruction
// - wb_cyc_o, wb_stb_o, wb_we_o  out 1  bus cycle / strobe / write (registered)
// - wb_adr_o       out  32  word address, bits[1:0]=0 (registered)
// - wb_sel_o       out  4   byte enables, bit3 = bits[31:24] (registered)
// - wb_dat_o       out  32  lane-replicated store data (registered)
// - wb_dat_i       in   32  read data; wb_ack_i in 1 transfer acknowledge
// - wd_o out 5, wreg_o out 1, wdata_o out 32   writeback toward MEM/WB
// - stallreq_o     out  1   request pipeline hold
// - misalign_o     out  1   misaligned access, no bus cycle issued
// - buserr_o       out  1   one-cycle pulse on timeout abort
// BEHAVIOUR
// - Reset (rst low, async): IDLE, all wb_* outputs 0, rd_buf 0, timeout counter 0; all
//   combinational outputs forced 0.
// - Access = aluop in {LB,LBU,LH,LHU,LW,SB,SH,SW} and aligned; other aluops pass mem_* through, 0 wait.
// - Alignment: LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=0. Misaligned: misalign_o=1,
//   wreg_o=0, no bus cycle, no stall.
// - FSM IDLE:  access & !flush_i -> stallreq_o=1; next edge registers cyc=stb=1, we, sel, adr, dat -> BUSY.
// - FSM BUSY:  !ack -> stallreq_o=1, counter++. ack -> stallreq_o=0, wdata_o from wb_dat_i (same cycle),
//   rd_buf<=aligned data, cyc/stb<=0; -> IDLE if stall_i[4]=NoStop else WAIT.
// - FSM WAIT:  stallreq_o=0, wdata_o=rd_buf; -> IDLE when stall_i[4]=NoStop (prevents reissue).
// - flush_i in BUSY: ack that cycle ignored, cyc/stb<=0, wreg_o=0, -> IDLE. flush_i in WAIT -> IDLE.
// - Timeout: counter reaches TIMEOUT in BUSY -> cyc/stb<=0, buserr_o pulse, wreg_o=0, -> IDLE.
// - Lanes (big-endian): byte at addr[1:0]=00 -> sel 1000, data[31:24]; 11 -> 0001, data[7:0];
//   half at 00 -> 1100, 10 -> 0011; word -> 1111. SB replicates byte x4, SH half x2.
// - Loads: LB/LH sign-extend, LBU/LHU zero-extend to 32. Stores: wreg_o passes mem_wreg_i (normally 0).
// - Minimum load latency: 2 cycles (decide + ack-in-first-BUSY-cycle); one stall cycle seen by pipeline.
// STRUCTURE
// - define.v: EXE_L*/EXE_S* aluop codes, Stop/NoStop, ZeroWord, state encodings (IDLE/BUSY/WAIT).
// - Sub-module mem_lane_align: combinational sel generation, store replication, load extract/extend.
// - Top: FSM, registered bus outputs, rd_buf, timeout counter, writeback mux.
// TESTING
// - LB addr 0x103, slave data 0x11223380, ack 1st BUSY cycle -> sel 0001, wdata_o 0xFFFFFF80, 1 stall cycle.
// - SH addr 0x202 data 0x0000BEEF -> we=1, sel 0011, adr 0x200, dat 0xBEEFBEEF; wreg_o 0.
// - LW addr 0x101 -> misalign_o=1, wreg_o=0, cyc never asserted, stallreq_o 0.
// - LHU with 3 wait states, stall_i[4]=Stop 2 cycles after ack -> WAIT holds rd_buf, no second cycle.
// - No ack, TIMEOUT=16 -> cyc drops after 16 BUSY cycles, buserr_o 1 cycle, back to IDLE.
// - rst low mid-BUSY -> cyc/stb/sel drop asynchronously; after release, fresh LW runs normally.

Source files
------------

// File: rtl/mem_wb_bus_master_pkg.sv
// mem_wb_bus_master_pkg: aluop codes, stall levels and FSM states shared by the memory-stage bus master
package mem_wb_bus_master_pkg;
  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
  localparam logic STOP = 1'b1;
  localparam logic NO_STOP = 1'b0;
  localparam logic [31:0] ZERO_WORD = 32'h0;
  typedef enum logic [1:0] {IDLE, BUSY, WAIT} state_t;
endpackage

// File: rtl/mem_wb_bus_master_lane_align.sv
// mem_lane_align: big-endian byte-lane select, store replication and load extract/extend
module mem_lane_align
  import mem_wb_bus_master_pkg::*;
(
  input  logic [7:0]  aluop,
  input  logic [1:0]  off,
  input  logic [31:0] st_data,
  input  logic [31:0] rd_data,
  output logic        is_load,
  output logic        is_store,
  output logic        misalign,
  output logic [3:0]  sel,
  output logic [31:0] wdat,
  output logic [31:0] rdat
);
  logic is_b, is_h, is_w, sx;
  logic [7:0] b;
  logic [15:0] h;
  // Decode access size, then steer lanes: offset 0 is the most significant byte
  always_comb begin
    is_b = aluop inside {EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP};
    is_h = aluop inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP};
    is_w = aluop inside {EXE_LW_OP, EXE_SW_OP};
    is_load = aluop inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
    is_store = aluop inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    sx = aluop inside {EXE_LB_OP, EXE_LH_OP};
    misalign = (is_h & off[0]) | (is_w & |off);
    sel = is_b ? 4'b1000 >> off : is_h ? (off[1] ? 4'b0011 : 4'b1100) : is_w ? 4'b1111 : 4'b0000;
    wdat = is_b ? {4{st_data[7:0]}} : is_h ? {2{st_data[15:0]}} : st_data;
    b = rd_data[{~off, 3'b000} +: 8];
    h = off[1] ? rd_data[15:0] : rd_data[31:16];
    rdat = is_b ? {{24{sx & b[7]}}, b} : is_h ? {{16{sx & h[15]}}, h} : rd_data;
  end
endmodule

// File: rtl/mem_wb_bus_master.sv
// mem_wb_bus_master: runs one Wishbone-classic cycle per memory-stage load/store and stalls until ack
module mem_wb_bus_master
  import mem_wb_bus_master_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  mem_aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_reg2_i,
  input  logic [4:0]  mem_wd_i,
  input  logic        mem_wreg_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq_o,
  output logic        misalign_o,
  output logic        buserr_o
);
  state_t state, state_nx;
  logic [7:0] cnt;
  logic [31:0] rd_buf, wdat, rdat;
  logic [3:0] sel;
  logic is_load, is_store, misalign, access, ack, tmo, abort, issue, hold;
  logic unused_stall;
  assign unused_stall = ^{stall_i[5], stall_i[3:0]};
  mem_lane_align u_lane (
    .aluop(mem_aluop_i), .off(mem_addr_i[1:0]), .st_data(mem_reg2_i), .rd_data(wb_dat_i),
    .is_load(is_load), .is_store(is_store), .misalign(misalign), .sel(sel), .wdat(wdat), .rdat(rdat)
  );
  // Next state, stall request and writeback mux; outputs held at zero while in reset
  always_comb begin
    access = (is_load | is_store) & ~misalign;
    hold = stall_i[4] == STOP;
    ack = state == BUSY && wb_ack_i && !flush_i;
    tmo = TIMEOUT != 0 && state == BUSY && !wb_ack_i && !flush_i && cnt == 8'(TIMEOUT - 1);
    abort = state == BUSY && (flush_i || tmo);
    issue = state == IDLE && access && !flush_i;
    state_nx = issue ? BUSY : abort ? IDLE : ack ? (hold ? WAIT : IDLE) :
               (state == WAIT && (!hold || flush_i)) ? IDLE : state;
    stallreq_o = rst & (issue | (state == BUSY & ~wb_ack_i & ~abort));
    misalign_o = rst & misalign;
    buserr_o = rst & tmo;
    wd_o = rst ? mem_wd_i : 5'd0;
    wreg_o = rst & mem_wreg_i & ~misalign & ~abort;
    wdata_o = !rst ? ZERO_WORD : (is_load && state == BUSY) ? rdat :
              (is_load && state == WAIT) ? rd_buf : mem_wdata_i;
  end
  // State, registered bus signals, wait-state counter and load data buffer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o <= 1'b0;
      wb_adr_o <= ZERO_WORD;
      wb_sel_o <= 4'b0;
      wb_dat_o <= ZERO_WORD;
      cnt <= 8'd0;
      rd_buf <= ZERO_WORD;
    end else begin
      state <= state_nx;
      if (issue) begin
        wb_cyc_o <= 1'b1;
        wb_stb_o <= 1'b1;
        wb_we_o <= is_store;
        wb_sel_o <= sel;
        wb_adr_o <= {mem_addr_i[31:2], 2'b00};
        wb_dat_o <= wdat;
      end else if (ack || abort) begin
        wb_cyc_o <= 1'b0;
        wb_stb_o <= 1'b0;
      end
      cnt <= (state == BUSY && !wb_ack_i && !abort) ? cnt + 8'd1 : 8'd0;
      if (ack) rd_buf <= rdat;
    end
  end
endmodule

// File: tb/tb_mem_wb_bus_master.sv
// tb_mem_wb_bus_master: directed checks of lane steering, wait states, misalign, timeout, flush and reset
module tb_mem_wb_bus_master;
  import mem_wb_bus_master_pkg::*;
  logic clk = 1'b0, rst = 1'b0;
  logic [7:0] mem_aluop_i = '0;
  logic [31:0] mem_addr_i = '0, mem_reg2_i = '0, mem_wdata_i = '0, wb_dat_i = '0;
  logic [4:0] mem_wd_i = '0;
  logic mem_wreg_i = 1'b0, flush_i = 1'b0, wb_ack_i = 1'b0;
  logic [5:0] stall_i = '0;
  logic wb_cyc_o, wb_stb_o, wb_we_o, wreg_o, stallreq_o, misalign_o, buserr_o;
  logic [31:0] wb_adr_o, wb_dat_o, wdata_o;
  logic [3:0] wb_sel_o;
  logic [4:0] wd_o;
  int n_tests = 0, n_fail = 0, busy, errs;
  logic err_wreg;

  mem_wb_bus_master #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .mem_aluop_i(mem_aluop_i), .mem_addr_i(mem_addr_i),
    .mem_reg2_i(mem_reg2_i), .mem_wd_i(mem_wd_i), .mem_wreg_i(mem_wreg_i),
    .mem_wdata_i(mem_wdata_i), .stall_i(stall_i), .flush_i(flush_i),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stallreq_o(stallreq_o),
    .misalign_o(misalign_o), .buserr_o(buserr_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [7:0] a, input logic [31:0] ad, input logic [31:0] sd, input logic wr);
    mem_aluop_i = a;
    mem_addr_i = ad;
    mem_reg2_i = sd;
    mem_wreg_i = wr;
    mem_wd_i = 5'd5;
  endtask

  task automatic nop;
    op(8'h00, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    #12;
    check("rst_cyc", wb_cyc_o, 0);
    check("rst_sel", wb_sel_o, 0);
    check("rst_adr", wb_adr_o, 0);
    check("rst_stall", stallreq_o, 0);
    rst = 1'b1;
    // LB 0x103, ack in first BUSY cycle
    tick;
    op(EXE_LB_OP, 32'h103, 32'h0, 1'b1);
    #1;
    check("lb_stall", stallreq_o, 1);
    check("lb_cyc_idle", wb_cyc_o, 0);
    tick;
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h1122_3380;
    #1;
    check("lb_cyc", wb_cyc_o, 1);
    check("lb_stb", wb_stb_o, 1);
    check("lb_we", wb_we_o, 0);
    check("lb_sel", wb_sel_o, 4'b0001);
    check("lb_adr", wb_adr_o, 32'h100);
    check("lb_stall_ack", stallreq_o, 0);
    check("lb_wdata", wdata_o, 32'hFFFF_FF80);
    check("lb_wreg", wreg_o, 1);
    tick;
    nop;
    wb_ack_i = 1'b0;
    #1;
    check("lb_cyc_end", wb_cyc_o, 0);
    // SH 0x202
    op(EXE_SH_OP, 32'h202, 32'h0000_BEEF, 1'b0);
    #1;
    check("sh_stall", stallreq_o, 1);
    tick;
    wb_ack_i = 1'b1;
    #1;
    check("sh_we", wb_we_o, 1);
    check("sh_sel", wb_sel_o, 4'b0011);
    check("sh_adr", wb_adr_o, 32'h200);
    check("sh_dat", wb_dat_o, 32'hBEEF_BEEF);
    check("sh_wreg", wreg_o, 0);
    check("sh_stall_ack", stallreq_o, 0);
    tick;
    nop;
    wb_ack_i = 1'b0;
    // LW misaligned
    op(EXE_LW_OP, 32'h101, 32'h0, 1'b1);
    #1;
    check("lw_mis", misalign_o, 1);
    check("lw_mis_wreg", wreg_o, 0);
    check("lw_mis_stall", stallreq_o, 0);
    tick;
    check("lw_mis_cyc1", wb_cyc_o, 0);
    tick;
    check("lw_mis_cyc2", wb_cyc_o, 0);
    nop;
    // SB 0x001 byte replication
    op(EXE_SB_OP, 32'h001, 32'h0000_00A5, 1'b0);
    tick;
    check("sb_sel", wb_sel_o, 4'b0100);
    check("sb_dat", wb_dat_o, 32'hA5A5_A5A5);
    wb_ack_i = 1'b1;
    tick;
    wb_ack_i = 1'b0;
    nop;
    // LHU 0x002, three wait states, pipeline hold for two cycles after ack
    op(EXE_LHU_OP, 32'h002, 32'h0, 1'b1);
    tick;
    repeat (3) begin
      #1;
      check("lhu_wait_stall", stallreq_o, 1);
      tick;
    end
    stall_i = 6'h10;
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h1234_ABCD;
    #1;
    check("lhu_ack_stall", stallreq_o, 0);
    check("lhu_ack_wdata", wdata_o, 32'h0000_ABCD);
    tick;
    wb_ack_i = 1'b0;
    wb_dat_i = 32'hFFFF_FFFF;
    #1;
    check("lhu_wait1_wdata", wdata_o, 32'h0000_ABCD);
    check("lhu_wait1_cyc", wb_cyc_o, 0);
    check("lhu_wait1_stall", stallreq_o, 0);
    tick;
    check("lhu_wait2_wdata", wdata_o, 32'h0000_ABCD);
    check("lhu_wait2_cyc", wb_cyc_o, 0);
    stall_i = 6'h00;
    tick;
    nop;
    #1;
    check("lhu_no_reissue", wb_cyc_o, 0);
    tick;
    check("lhu_idle_cyc", wb_cyc_o, 0);
    // LW 0x300 with no ack: timeout
    op(EXE_LW_OP, 32'h300, 32'h0, 1'b1);
    busy = 0;
    errs = 0;
    err_wreg = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (!wb_cyc_o) break;
      busy++;
      if (buserr_o) begin
        errs++;
        err_wreg = wreg_o;
      end
    end
    nop;
    #1;
    check("tmo_busy_cycles", busy, 16);
    check("tmo_buserr_pulses", errs, 1);
    check("tmo_wreg", err_wreg, 0);
    check("tmo_stall_after", stallreq_o, 0);
    // Flush in BUSY ignores ack
    op(EXE_LW_OP, 32'h400, 32'h0, 1'b1);
    tick;
    flush_i = 1'b1;
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h5555_AAAA;
    #1;
    check("flush_stall", stallreq_o, 0);
    check("flush_wreg", wreg_o, 0);
    tick;
    flush_i = 1'b0;
    wb_ack_i = 1'b0;
    nop;
    #1;
    check("flush_cyc", wb_cyc_o, 0);
    // Non-memory op passes through
    mem_aluop_i = 8'h20;
    mem_wdata_i = 32'hDEAD_BEEF;
    mem_wreg_i = 1'b1;
    mem_wd_i = 5'd7;
    #1;
    check("pass_wdata", wdata_o, 32'hDEAD_BEEF);
    check("pass_wreg", wreg_o, 1);
    check("pass_wd", wd_o, 7);
    check("pass_stall", stallreq_o, 0);
    // Asynchronous reset mid-BUSY
    op(EXE_LW_OP, 32'h500, 32'h0, 1'b1);
    tick;
    check("ar_cyc_before", wb_cyc_o, 1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_cyc", wb_cyc_o, 0);
    check("ar_stb", wb_stb_o, 0);
    check("ar_sel", wb_sel_o, 0);
    check("ar_stall", stallreq_o, 0);
    nop;
    #3;
    rst = 1'b1;
    tick;
    op(EXE_LW_OP, 32'h600, 32'h0, 1'b1);
    #1;
    check("ar_lw_stall", stallreq_o, 1);
    tick;
    wb_ack_i = 1'b1;
    wb_dat_i = 32'hCAFE_F00D;
    #1;
    check("ar_lw_cyc", wb_cyc_o, 1);
    check("ar_lw_adr", wb_adr_o, 32'h600);
    check("ar_lw_sel", wb_sel_o, 4'b1111);
    check("ar_lw_wdata", wdata_o, 32'hCAFE_F00D);
    tick;
    wb_ack_i = 1'b0;
    nop;
    #1;
    check("ar_lw_end", wb_cyc_o, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
